// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch/jump resolution with load-use stall and single-cycle redirect.
// Latency: stall is combinational; redirect/flush_id/target follow one cycle after the evaluate cycle.
// Backpressure: stall freezes PC and IF/ID while the operand is busy; kill overrides all inputs.
// Optional feature: define BRANCH_STAT_EN to enable the statistics counters.
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic        opnd_busy,
    input  logic        sign,
    input  logic        zero,
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic [25:0] idx26,
    input  logic        kill,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] target,
    output logic        flush_id,
    output logic [31:0] stat_br,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_target;
    logic        w_taken;
    logic        w_eval;
    logic        w_stall;
    logic        w_redirect;
    logic        w_take;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_new_target;

    // Taken condition from comparator flags; op 7 is reserved and never taken
    always_comb begin
        w_taken = 1'b0;
        case (br_op)
            3'd0:    w_taken = zero;
            3'd1:    w_taken = ~zero;
            3'd2:    w_taken = sign | zero;
            3'd3:    w_taken = ~sign & ~zero;
            3'd4:    w_taken = sign;
            3'd5:    w_taken = ~sign;
            3'd6:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // Word offset is sign-extended and scaled; the add wraps silently
    assign w_br_target  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign w_j_target   = {pc_plus4[31:28], idx26, 2'b00};
    assign w_new_target = (br_op == 3'd6) ? w_j_target : w_br_target;

    // Next-state and raw outputs; kill squashes everything in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_redirect  = 1'b0;
        w_eval      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (br_valid) begin
                    if (opnd_busy) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_eval      = 1'b1;
                        w_state_nxt = w_taken ? S_REDIR : S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (opnd_busy) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_eval      = br_valid;
                    w_state_nxt = (br_valid && w_taken) ? S_REDIR : S_IDLE;
                end
            end
            S_REDIR: begin
                // The instruction now in ID is on the wrong path, so br_valid is ignored
                w_redirect  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (kill) begin
            w_state_nxt = S_IDLE;
            w_stall     = 1'b0;
            w_redirect  = 1'b0;
            w_eval      = 1'b0;
        end
    end

    assign w_take   = w_eval & w_taken;
    assign stall    = w_stall & ~rst;
    assign redirect = w_redirect & ~rst;
    assign flush_id = w_redirect & ~rst;
    assign target   = r_target;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Capture the redirect address only on a taken evaluation; holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_target <= 32'h0000_0000;
        else if (w_take) r_target <= w_new_target;
    end

`ifdef BRANCH_STAT_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_stall;

    // Free-running wrap-around statistics; kill never rolls a count back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_br    <= 32'd0;
            r_stat_taken <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_eval)  r_stat_br    <= r_stat_br + 32'd1;
            if (w_take)  r_stat_taken <= r_stat_taken + 32'd1;
            if (w_stall) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_br    = r_stat_br;
    assign stat_taken = r_stat_taken;
    assign stat_stall = r_stat_stall;
`else
    assign stat_br    = 32'd0;
    assign stat_taken = 32'd0;
    assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed scenarios for branch_ctrl with a per-cycle reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// The model tracks only "redirect pending" and the last target, not the DUT state machine.
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [2:0]  br_op;
    logic        opnd_busy;
    logic        sign;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic [25:0] idx26;
    logic        kill;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        flush_id;
    logic [31:0] stat_br;
    logic [31:0] stat_taken;
    logic [31:0] stat_stall;

    int n_total = 0;
    int n_pass  = 0;

    branch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .br_valid   (br_valid),
        .br_op      (br_op),
        .opnd_busy  (opnd_busy),
        .sign       (sign),
        .zero       (zero),
        .pc_plus4   (pc_plus4),
        .imm16      (imm16),
        .idx26      (idx26),
        .kill       (kill),
        .stall      (stall),
        .redirect   (redirect),
        .target     (target),
        .flush_id   (flush_id),
        .stat_br    (stat_br),
        .stat_taken (stat_taken),
        .stat_stall (stat_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Statistics are only live when the counters are built in
    function automatic logic [31:0] se(input logic [31:0] v);
`ifdef BRANCH_STAT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    // ---------------- reference model ----------------
    bit          m_redir = 1'b0;
    logic [31:0] m_tgt   = 32'd0;
    logic [31:0] m_br = 32'd0, m_tk = 32'd0, m_st = 32'd0;
    bit          n_redir = 1'b0;
    logic [31:0] n_tgt   = 32'd0;
    logic [31:0] n_br = 32'd0, n_tk = 32'd0, n_st = 32'd0;

    function automatic bit m_taken(input int op, input bit s, input bit z);
        // s/z describe Data1-Data2; Data2 is 0 for the compare-with-zero ops
        case (op)
            0: return z;
            1: return !z;
            2: return s || z;
            3: return !s && !z;
            4: return s;
            5: return !s;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_dest(input int op, input logic [31:0] pc,
                                           input logic [15:0] imm, input logic [25:0] idx);
        logic signed [31:0] off;
        if (op == 6) return (pc & 32'hF000_0000) | (32'(idx) * 32'd4);
        off = $signed(imm);
        return pc + off * 4;
    endfunction

    // Compare and compute the model's next values every falling edge
    always @(negedge clk) begin
        bit ev;
        bit st;
        bit rd;
        bit tk;
        if (rst) begin
            chk("m_rst_stall", {31'd0, stall}, 32'd0);
            chk("m_rst_redirect", {31'd0, redirect}, 32'd0);
            chk("m_rst_flush", {31'd0, flush_id}, 32'd0);
            n_redir = 1'b0; n_tgt = 32'd0;
            n_br = 32'd0; n_tk = 32'd0; n_st = 32'd0;
        end else begin
            st = !kill && !m_redir && br_valid && opnd_busy;
            ev = !kill && !m_redir && br_valid && !opnd_busy;
            rd = m_redir && !kill;
            tk = ev && m_taken(int'(br_op), sign, zero);
            chk("m_stall", {31'd0, stall}, {31'd0, st});
            chk("m_redirect", {31'd0, redirect}, {31'd0, rd});
            chk("m_flush", {31'd0, flush_id}, {31'd0, rd});
            chk("m_target", target, m_tgt);
            chk("m_stat_br", stat_br, se(m_br));
            chk("m_stat_taken", stat_taken, se(m_tk));
            chk("m_stat_stall", stat_stall, se(m_st));
            n_redir = tk;
            n_tgt   = tk ? m_dest(int'(br_op), pc_plus4, imm16, idx26) : m_tgt;
            n_br    = m_br + (ev ? 32'd1 : 32'd0);
            n_tk    = m_tk + (tk ? 32'd1 : 32'd0);
            n_st    = m_st + (st ? 32'd1 : 32'd0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_redir = 1'b0; m_tgt = 32'd0;
            m_br = 32'd0; m_tk = 32'd0; m_st = 32'd0;
        end else begin
            m_redir = n_redir; m_tgt = n_tgt;
            m_br = n_br; m_tk = n_tk; m_st = n_st;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit v, input bit [2:0] op, input bit busy, input bit s, input bit z,
                       input bit [31:0] pc, input bit [15:0] imm, input bit [25:0] idx, input bit k);
        br_valid = v; br_op = op; opnd_busy = busy; sign = s; zero = z;
        pc_plus4 = pc; imm16 = imm; idx26 = idx; kill = k;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        // A stalling branch during reset must not raise stall
        drv(1'b1, 3'd0, 1'b1, 1'b0, 0, 32'd0, 16'd0, 26'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_flush", {31'd0, flush_id}, 32'd0);
        chk("reset_target", target, 32'h0000_0000);
        chk("reset_stat_br", stat_br, 32'd0);
        chk("reset_stat_stall", stat_stall, 32'd0);

        // BEQ taken, evaluated in the first cycle after reset release
        tick(); rst = 1'b0;
        drv(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 16'hFFFE, 26'd0, 1'b0);
        @(negedge clk); chk("beq_stall", {31'd0, stall}, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("beq_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_flush", {31'd0, flush_id}, 32'd1);
        chk("beq_target", target, 32'h0000_00FC);
        chk("beq_stat_taken", stat_taken, se(32'd1));

        // BNE not taken
        tick(); drv(1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 16'h0010, 26'd0, 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("bne_redirect", {31'd0, redirect}, 32'd0);
        chk("bne_stat_br", stat_br, se(32'd2));
        chk("bne_stat_taken", stat_taken, se(32'd1));

        // Load-use stall: BGTZ busy for two cycles, then taken
        tick(); drv(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 16'h0010, 26'd0, 1'b0);
        @(negedge clk); chk("lu_stall_c1", {31'd0, stall}, 32'd1);
        tick();
        @(negedge clk); chk("lu_stall_c2", {31'd0, stall}, 32'd1);
        tick(); opnd_busy = 1'b0;
        @(negedge clk);
        chk("lu_stall_c3", {31'd0, stall}, 32'd0);
        chk("lu_redirect_c3", {31'd0, redirect}, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("lu_redirect_c4", {31'd0, redirect}, 32'd1);
        chk("lu_target", target, 32'h0000_1040);
        chk("lu_stat_stall", stat_stall, se(32'd2));
        chk("lu_stat_br", stat_br, se(32'd3));

        // Jump with region wrap; a stalling branch seen during the redirect is ignored
        tick(); drv(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 32'hF000_0000, 16'd0, 26'h3FF_FFFF, 1'b0);
        tick(); drv(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 16'h0001, 26'd0, 1'b0);
        @(negedge clk);
        chk("j_redirect", {31'd0, redirect}, 32'd1);
        chk("j_target", target, 32'hFFFF_FFFC);
        chk("j_redir_ignores_br", {31'd0, stall}, 32'd0);

        // Branch target wrapping past 2^32
        tick(); drv(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 16'h0001, 26'd0, 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("wrap_redirect", {31'd0, redirect}, 32'd1);
        chk("wrap_target", target, 32'h0000_0000);
        chk("wrap_stat_taken", stat_taken, se(32'd4));

        // kill in WAIT in the same cycle the operand becomes ready
        tick(); drv(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 16'h0004, 26'd0, 1'b0);
        @(negedge clk); chk("kw_stall_wait", {31'd0, stall}, 32'd1);
        tick(); drv(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 16'h0004, 26'd0, 1'b1);
        @(negedge clk);
        chk("kw_stall_kill", {31'd0, stall}, 32'd0);
        chk("kw_redirect_kill", {31'd0, redirect}, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("kw_redirect_after", {31'd0, redirect}, 32'd0);
        chk("kw_target_held", target, 32'h0000_0000);
        chk("kw_stat_br", stat_br, se(32'd5));
        chk("kw_stat_stall", stat_stall, se(32'd3));

        // Reserved op 7 is never taken
        tick(); drv(1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 16'h0008, 26'd0, 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("op7_redirect", {31'd0, redirect}, 32'd0);
        chk("op7_stat_br", stat_br, se(32'd6));

        // kill arriving in the redirect cycle suppresses it
        tick(); drv(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 16'h0008, 26'd0, 1'b0);
        tick(); drv(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0, 1'b1);
        @(negedge clk);
        chk("kr_redirect", {31'd0, redirect}, 32'd0);
        chk("kr_flush", {31'd0, flush_id}, 32'd0);
        chk("kr_target", target, 32'h0000_0420);

        // Condition sweep: every op against (sign,zero) = 00, 01, 10
        for (int op = 0; op < 8; op++) begin
            for (int sz = 0; sz < 3; sz++) begin
                tick(); drv(1'b1, 3'(op), 1'b0, sz == 2, sz == 1,
                            32'h0001_0000 + 32'(op * 64), 16'(16'h0100 + 16'(sz)), 26'h12_3456, 1'b0);
                tick(); idle();
            end
        end

        // Asynchronous reset while the redirect is showing
        tick(); drv(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 16'h0001, 26'd0, 1'b0);
        tick(); idle();
        #1;
        chk("ar_redirect_before", {31'd0, redirect}, 32'd1);
        chk("ar_target_before", target, 32'h0000_0504);
        #1 rst = 1'b1;
        #1;
        chk("ar_redirect_drop", {31'd0, redirect}, 32'd0);
        chk("ar_flush_drop", {31'd0, flush_id}, 32'd0);
        chk("ar_target_zero", target, 32'h0000_0000);
        tick(); tick(); rst = 1'b0;
        @(negedge clk); chk("ar_no_redirect_1", {31'd0, redirect}, 32'd0);
        tick();
        @(negedge clk); chk("ar_no_redirect_2", {31'd0, redirect}, 32'd0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- br_valid  in  1  ID-stage instruction is a branch or jump.
- br_op  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 J; 7 reserved, treated as not-taken.
- opnd_busy  in  1  branch operand not yet forwardable; the hazard unit asserts this for a load in EX.
- sign  in  1  bit 31 of Data1-Data2 from the comparator.
- zero  in  1  Data1==Data2 from the comparator.
- pc_plus4  in  32  PC+4 of the branch.
- imm16  in  16  branch offset, in words.
- idx26  in  26  jump index.
- kill  in  1  later-stage exception flush.
- stall  out  1  freeze PC and IF/ID.
- redirect  out  1  load PC from target.
- target  out  32  redirect address.
- flush_id  out  1  squash the instruction in IF/ID.
- stat_br, stat_taken, stat_stall  out  32 each  statistics counters (see Configuration).

Function
REQ-002 The block SHALL implement three states: IDLE, WAIT, REDIR.
REQ-003 The taken condition SHALL be:
- BEQ: zero.
- BNE: !zero.
- BLEZ: sign|zero.
- BGTZ: !sign&!zero.
- BLTZ: sign.
- BGEZ: !sign.
- J: 1.
- For br_op 2-5 the upstream logic drives Data2=0.
REQ-004 The branch target SHALL be pc_plus4 + (sign-extended imm16 << 2), modulo 2^32, with wrap-around permitted and not flagged.
REQ-005 The jump target SHALL be {pc_plus4[31:28], idx26, 2'b00}.
REQ-006 IDLE, br_valid=1, opnd_busy=1: stall SHALL be 1 combinationally in the same cycle, and the next state SHALL be WAIT.
REQ-007 IDLE or WAIT, br_valid=1, opnd_busy=0 (evaluate cycle): the block SHALL sample sign, zero and br_op.
- Taken: target is registered and the next state is REDIR.
- Not taken: the next state is IDLE.
- stall is 0 in the evaluate cycle.
REQ-008 WAIT SHALL hold stall=1 while opnd_busy=1, for an unbounded number of cycles; br_valid and all operand inputs are held stable by the stall.
REQ-009 REDIR SHALL assert redirect=1 and flush_id=1 for exactly one cycle and then return to IDLE. This gives a redirect latency of 1 cycle after the evaluate cycle.
REQ-010 REDIR SHALL ignore br_valid, because the instruction in ID is on the wrong path and is squashed.
REQ-011 target SHALL hold its last registered value outside REDIR. It is only meaningful while redirect=1.
REQ-012 kill=1 SHALL force the next state to IDLE from any state and suppress any pending redirect. kill has priority over all other inputs.
REQ-013 While kill=1, outputs stall, redirect and flush_id SHALL be 0 in that cycle.
REQ-014 br_op=7 SHALL be evaluated as not-taken and SHALL NOT raise any error.

Reset
REQ-015 Asserting rst SHALL asynchronously force:
- state to IDLE;
- stall, redirect and flush_id to 0;
- target to 32'h0000_0000;
- all stat counters to 0.
REQ-016 Reset asserted mid-WAIT or mid-REDIR SHALL abandon the branch with no redirect after release.
REQ-017 The first evaluation SHALL be possible in the first clock edge after rst deasserts.

Configuration
REQ-018 With macro BRANCH_STAT_EN defined, the statistics counters SHALL count as follows, each wrapping modulo 2^32:
- stat_br increments once per evaluate cycle.
- stat_taken increments once per taken evaluation.
- stat_stall increments on every cycle with stall=1.
- kill SHALL NOT roll back any count.
REQ-019 Without BRANCH_STAT_EN, the stat ports SHALL remain present, be tied to 0, and no counter flops SHALL be inferred.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- BEQ taken: pc_plus4=32'h0000_0104, imm16=16'hFFFE, zero=1. Required response: redirect=1 and flush_id=1 one cycle later, target=32'h0000_00FC, stall never asserted.
- BNE not taken: zero=1. Required response: redirect stays 0, state returns to IDLE, stat_taken unchanged and stat_br +1 (with BRANCH_STAT_EN).
- Load-use stall: BGTZ with opnd_busy=1 for 2 cycles, then 0 with sign=0, zero=0. Required response: stall=1 for exactly 2 cycles, redirect on the 4th cycle, stat_stall=2.
- Jump with wrap: J with pc_plus4=32'hF000_0000, idx26=26'h3FF_FFFF. Required response: target=32'hFFFF_FFFC. Branch wrap: pc_plus4=32'hFFFF_FFFC, imm16=16'h0001. Required response: target=32'h0000_0000.
- kill during WAIT: a BEQ in WAIT receives kill=1 in the same cycle opnd_busy drops with zero=1. Required response: no redirect, stall=0, state IDLE.
- Async reset in REDIR: rst asserted mid-cycle. Required response: redirect and flush_id drop immediately, target=0, and no redirect occurs after release.
